// File: rtl/cpu_types_pkg.sv
// Shared CPU types: words, register indices, opcodes
// and the writeback destination selector.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    ADDI  = 6'h08,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [1:0] {
    RD_RT,
    RD_RD,
    RD_R31,
    RD_NONE
  } regdst_t;
endpackage

// File: rtl/register_file.sv
// Register storage with two combinational read ports
// and write-first bypass; r0 always reads zero.
module register_file
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     wen_i,
  input  regbits_t wsel_i,
  input  word_t    wdat_i,
  input  regbits_t rsel1_i,
  input  regbits_t rsel2_i,
  output word_t    rdat1_o,
  output word_t    rdat2_o
);

  word_t regs_q [NREGS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen_i && (wsel_i != '0)) begin
      regs_q[wsel_i] <= wdat_i;
    end
  end

  function automatic word_t rd_port(
    input regbits_t sel
  );
    word_t r;
    r = regs_q[sel];
    if (sel == '0) begin
      r = '0;
    end else if (wen_i && (sel == wsel_i)) begin
      r = wdat_i;
    end
    return r;
  endfunction

  always_comb begin
    rdat1_o = rd_port(rsel1_i);
    rdat2_o = rd_port(rsel2_i);
  end

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: result/destination select, regfile
// commit, sticky halt and retired-instruction counter.
module writeback_regfile
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             RegW,
  input  logic [1:0]       RegDest,
  input  regbits_t         Rd,
  input  regbits_t         Rt,
  input  logic [5:0]       opcode,
  input  logic             Mem,
  input  logic             lui,
  input  word_t            aluout,
  input  word_t            dload,
  input  word_t            extout,
  input  word_t            npc,
  input  logic             halt_in,
  input  regbits_t         rsel1,
  input  regbits_t         rsel2,
  output word_t            rdat1,
  output word_t            rdat2,
  output logic             wb_en,
  output regbits_t         wb_sel,
  output word_t            wb_dat,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  logic             halt_q, halt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  regbits_t         sel_raw;
  word_t            dat_raw;
  logic             valid;

  always_comb begin
    sel_raw = '0;
    unique case (regdst_t'(RegDest))
      RD_RT:   sel_raw = Rt;
      RD_RD:   sel_raw = Rd;
      RD_R31:  sel_raw = 5'd31;
      RD_NONE: sel_raw = '0;
    endcase
  end

  always_comb begin
    dat_raw = aluout;
    if (opcode == JAL) begin
      dat_raw = npc;
    end else if (lui) begin
      dat_raw = extout;
    end else if (Mem) begin
      dat_raw = dload;
    end
  end

  // Held reset blanks the forwarding outputs too.
  assign wb_en  = nRST & RegW & (sel_raw != '0) & ~halt_q;
  assign wb_sel = nRST ? sel_raw : '0;
  assign wb_dat = nRST ? dat_raw : '0;

  // Flushed bubbles arrive as all-zero RTYPE with no RegW.
  assign valid = RegW | (opcode != RTYPE) | halt_in;

  always_comb begin
    halt_d    = halt_q;
    retired_d = retired_q;
    if (!halt_q) begin
      if (halt_in) begin
        halt_d = 1'b1;
      end
      if (valid) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      halt_q    <= halt_d;
      retired_q <= retired_d;
    end
  end

  assign halt    = halt_q;
  assign retired = retired_q;

  register_file #(
    .NREGS(NREGS)
  ) u_rf (
    .CLK     (CLK),
    .nRST    (nRST),
    .wen_i   (wb_en),
    .wsel_i  (wb_sel),
    .wdat_i  (wb_dat),
    .rsel1_i (rsel1),
    .rsel2_i (rsel2),
    .rdat1_o (rdat1),
    .rdat2_o (rdat2)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an
// array-based architectural model.
module tb_writeback_regfile;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        RegW;
  logic [1:0]  RegDest;
  logic [4:0]  Rd, Rt;
  logic [5:0]  opcode;
  logic        Mem, lui;
  logic [31:0] aluout, dload, extout, npc;
  logic        halt_in;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rdat1, rdat2;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        halt;
  logic [31:0] retired;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_rf [32];
  bit          m_halt;
  logic [31:0] m_ret;

  always #5 CLK = ~CLK;

  writeback_regfile #(
    .NREGS(32),
    .CNT_W(32)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .RegW    (RegW),
    .RegDest (RegDest),
    .Rd      (Rd),
    .Rt      (Rt),
    .opcode  (opcode),
    .Mem     (Mem),
    .lui     (lui),
    .aluout  (aluout),
    .dload   (dload),
    .extout  (extout),
    .npc     (npc),
    .halt_in (halt_in),
    .rsel1   (rsel1),
    .rsel2   (rsel2),
    .rdat1   (rdat1),
    .rdat2   (rdat2),
    .wb_en   (wb_en),
    .wb_sel  (wb_sel),
    .wb_dat  (wb_dat),
    .halt    (halt),
    .retired (retired)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    RegW = 0; RegDest = 0; Rd = 0; Rt = 0;
    opcode = 0; Mem = 0; lui = 0;
    aluout = 0; dload = 0; extout = 0; npc = 0;
    halt_in = 0; rsel1 = 0; rsel2 = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_halt = 0;
    m_ret  = '0;
  endtask

  function automatic logic [31:0] m_read(
    input logic [4:0]  a,
    input logic        en,
    input logic [4:0]  s,
    input logic [31:0] d
  );
    if (a == 0) return '0;
    if (en && a == s) return d;
    return m_rf[a];
  endfunction

  // One instruction: check comb outputs, clock, update model.
  task automatic step();
    logic [4:0]  s;
    logic [31:0] d;
    logic        en;
    case (RegDest)
      2'd0:    s = Rt;
      2'd1:    s = Rd;
      2'd2:    s = 5'd31;
      default: s = 5'd0;
    endcase
    if (opcode == 6'h03)  d = npc;
    else if (lui)         d = extout;
    else if (Mem)         d = dload;
    else                  d = aluout;
    en = RegW && (s != 0) && !m_halt;
    #1;
    chk("wb_en", {31'b0, wb_en}, {31'b0, en});
    chk("wb_sel", {27'b0, wb_sel}, {27'b0, s});
    chk("wb_dat", wb_dat, d);
    chk("rdat1", rdat1, m_read(rsel1, en, s, d));
    chk("rdat2", rdat2, m_read(rsel2, en, s, d));
    @(posedge CLK);
    if (en) m_rf[s] = d;
    if (!m_halt && (RegW || opcode != 0 || halt_in))
      m_ret = m_ret + 1;
    if (!m_halt && halt_in) m_halt = 1;
    #1;
    chk("halt", {31'b0, halt}, {31'b0, m_halt});
    chk("retired", retired, m_ret);
    @(negedge CLK);
  endtask

  task automatic rand_in();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h03, 6'h08, 6'h23, 6'h0f, 6'h02};
    clr_in();
    if ($urandom_range(0, 7) == 0) begin
      rsel1 = 5'($urandom);
      rsel2 = 5'($urandom);
      return;
    end
    RegW    = ($urandom_range(0, 3) != 0);
    RegDest = 2'($urandom);
    Rd      = 5'($urandom);
    Rt      = 5'($urandom);
    opcode  = ops[$urandom_range(0, 5)];
    Mem     = ($urandom_range(0, 3) == 0);
    lui     = ($urandom_range(0, 5) == 0);
    aluout  = $urandom;
    dload   = $urandom;
    extout  = $urandom;
    npc     = $urandom;
    rsel1   = $urandom_range(0, 1) ? Rd : 5'($urandom);
    rsel2   = $urandom_range(0, 1) ? Rt : 5'($urandom);
  endtask

  logic [31:0] saved;

  initial begin
    clr_in();
    model_reset();
    nRST = 0;
    rsel1 = 5;
    rsel2 = 0;
    #1;
    chk("rst_rdat1", rdat1, 0);
    chk("rst_rdat2", rdat2, 0);
    chk("rst_halt", {31'b0, halt}, 0);
    chk("rst_retired", retired, 0);
    @(negedge CLK);
    nRST = 1;

    clr_in();
    RegW = 1; RegDest = 1; Rd = 5;
    aluout = 32'hDEAD_BEEF;
    rsel1 = 5;
    step();
    clr_in();
    rsel1 = 5;
    #1;
    chk("r5_hold", rdat1, 32'hDEAD_BEEF);
    chk("ret_one", retired, 1);

    clr_in();
    opcode = 6'h03; RegDest = 2; RegW = 1;
    npc = 32'h104; Mem = 1; lui = 1;
    extout = 32'h5555_0000; dload = 32'h77;
    aluout = 32'h99;
    step();
    clr_in();
    rsel2 = 31;
    #1;
    chk("jal_r31", rdat2, 32'h104);

    clr_in();
    opcode = 6'h0f; RegW = 1; RegDest = 0; Rt = 7;
    lui = 1; extout = 32'h1234_0000;
    aluout = 32'h1; dload = 32'h2;
    step();
    clr_in();
    rsel1 = 7;
    #1;
    chk("lui_r7", rdat1, 32'h1234_0000);

    clr_in();
    RegW = 1; RegDest = 0; Rt = 0; aluout = 7;
    step();
    #1;
    chk("r0_zero", rdat1, 0);

    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end

    saved = m_ret;
    for (int i = 0; i < 10; i++) begin
      clr_in();
      rsel1 = 5'(i);
      step();
    end
    chk("bubbles", retired, saved);

    clr_in();
    rsel1 = 3;
    #1;
    saved = rdat1;
    clr_in();
    opcode = 6'h3f; halt_in = 1;
    step();
    chk("halt_set", {31'b0, halt}, 1);
    saved = m_rf[3];
    for (int i = 0; i < 3; i++) begin
      clr_in();
      RegW = 1; RegDest = 1; Rd = 3;
      aluout = $urandom; opcode = 6'h08;
      rsel1 = 3; rsel2 = 3;
      step();
    end
    chk("halt_r3", rdat1, saved);
    chk("halt_ret", retired, m_ret);
    chk("halt_stays", {31'b0, halt}, 1);

    clr_in();
    RegW = 1; RegDest = 1; Rd = 9;
    aluout = 32'hCAFE_F00D; rsel1 = 9; rsel2 = 5;
    #2;
    nRST = 0;
    #1;
    chk("arst_rdat1", rdat1, 0);
    chk("arst_rdat2", rdat2, 0);
    chk("arst_wb_en", {31'b0, wb_en}, 0);
    chk("arst_wb_dat", wb_dat, 0);
    chk("arst_halt", {31'b0, halt}, 0);
    chk("arst_ret", retired, 0);
    model_reset();
    @(negedge CLK);
    nRST = 1;
    clr_in();
    rsel1 = 9; rsel2 = 31;
    step();
    chk("post_rst_r9", rdat1, 0);

    for (int i = 0; i < 40; i++) begin
      rand_in();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
